// File: rtl/vote_ballot_issuer.sv
// Ballot issuer: validates voter requests, drives one-hot vote lines toward the tally
// and keeps a shadow weighted total. Optional request skid buffer under BALLOT_SKID_EN.
module vote_ballot_issuer #(
   parameter int HOLD_CYCLES = 2,
   parameter int RSP_CODE_W  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_class,
   input  logic [4:0]            req_id,
   output logic [31:0]           np_out,
   output logic [7:0]            vip_out,
   output logic                  vvip_out,
   output logic                  rsp_valid,
   output logic                  rsp_ok,
   output logic [RSP_CODE_W-1:0] rsp_code,
   output logic [7:0]            issued_weight
);

   typedef enum logic [1:0] {IDLE, CHECK, DRIVE, RESP} state_t;

   localparam int          HOLD_EFF  = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_EFF - 1);

   localparam logic [1:0] CODE_OK   = 2'd0;
   localparam logic [1:0] CODE_DUP  = 2'd1;
   localparam logic [1:0] CODE_ILL  = 2'd2;

   state_t      state_q, state_d;
   logic [1:0]  cls_q, cls_d;
   logic [4:0]  id_q, id_d;
   logic [1:0]  code_q, code_d;
   logic [15:0] hold_q, hold_d;
   logic [31:0] np_used_q, np_used_d;
   logic [7:0]  vip_used_q, vip_used_d;
   logic        vvip_used_q, vvip_used_d;
   logic [7:0]  weight_q, weight_d;
   logic        accept;
   logic        illegal;
   logic        dup;

`ifdef BALLOT_SKID_EN
   logic        skid_full_q, skid_full_d;
   logic [1:0]  skid_cls_q, skid_cls_d;
   logic [4:0]  skid_id_q, skid_id_d;
   assign req_ready = !skid_full_q;
`else
   assign req_ready = (state_q == IDLE);
`endif

   assign accept  = req_valid && req_ready;
   assign illegal = (cls_q == 2'd3) || (cls_q == 2'd1 && id_q >= 5'd8) ||
                    (cls_q == 2'd2 && id_q != 5'd0);
   // Only meaningful once legality has been established.
   assign dup     = (cls_q == 2'd0) ? np_used_q[id_q] :
                    (cls_q == 2'd1) ? vip_used_q[id_q[2:0]] : vvip_used_q;

   always_comb begin
      state_d     = state_q;
      cls_d       = cls_q;
      id_d        = id_q;
      code_d      = code_q;
      hold_d      = hold_q;
      np_used_d   = np_used_q;
      vip_used_d  = vip_used_q;
      vvip_used_d = vvip_used_q;
      weight_d    = weight_q;
`ifdef BALLOT_SKID_EN
      skid_full_d = skid_full_q;
      skid_cls_d  = skid_cls_q;
      skid_id_d   = skid_id_q;
`endif
      case (state_q)
         IDLE, RESP: begin
`ifdef BALLOT_SKID_EN
            // A stored request takes precedence so ordering is preserved.
            if (skid_full_q) begin
               cls_d       = skid_cls_q;
               id_d        = skid_id_q;
               skid_full_d = 1'b0;
               state_d     = CHECK;
            end else
`endif
            if (accept) begin
               cls_d   = req_class;
               id_d    = req_id;
               state_d = CHECK;
            end else begin
               state_d = IDLE;
            end
         end
         CHECK: begin
            if (illegal) begin
               code_d  = CODE_ILL;
               state_d = RESP;
            end else if (dup) begin
               code_d  = CODE_DUP;
               state_d = RESP;
            end else begin
               code_d  = CODE_OK;
               hold_d  = 16'd0;
               state_d = DRIVE;
               case (cls_q)
                  2'd0: begin
                     np_used_d[id_q] = 1'b1;
                     weight_d        = weight_q + 8'd1;
                  end
                  2'd1: begin
                     vip_used_d[id_q[2:0]] = 1'b1;
                     weight_d              = weight_q + 8'd4;
                  end
                  default: begin
                     vvip_used_d = 1'b1;
                     weight_d    = weight_q + 8'd16;
                  end
               endcase
            end
         end
         DRIVE: begin
            if (hold_q == HOLD_LAST) state_d = RESP;
            else                     hold_d  = hold_q + 16'd1;
         end
         default: state_d = IDLE;
      endcase
`ifdef BALLOT_SKID_EN
      if (accept && (state_q == CHECK || state_q == DRIVE)) begin
         skid_full_d = 1'b1;
         skid_cls_d  = req_class;
         skid_id_d   = req_id;
      end
`endif
      if (clear) begin
         state_d     = IDLE;
         cls_d       = 2'd0;
         id_d        = 5'd0;
         code_d      = CODE_OK;
         hold_d      = 16'd0;
         np_used_d   = 32'd0;
         vip_used_d  = 8'd0;
         vvip_used_d = 1'b0;
         weight_d    = 8'd0;
`ifdef BALLOT_SKID_EN
         skid_full_d = 1'b0;
         skid_cls_d  = 2'd0;
         skid_id_d   = 5'd0;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cls_q       <= 2'd0;
         id_q        <= 5'd0;
         code_q      <= 2'd0;
         hold_q      <= 16'd0;
         np_used_q   <= 32'd0;
         vip_used_q  <= 8'd0;
         vvip_used_q <= 1'b0;
         weight_q    <= 8'd0;
`ifdef BALLOT_SKID_EN
         skid_full_q <= 1'b0;
         skid_cls_q  <= 2'd0;
         skid_id_q   <= 5'd0;
`endif
      end else begin
         state_q     <= state_d;
         cls_q       <= cls_d;
         id_q        <= id_d;
         code_q      <= code_d;
         hold_q      <= hold_d;
         np_used_q   <= np_used_d;
         vip_used_q  <= vip_used_d;
         vvip_used_q <= vvip_used_d;
         weight_q    <= weight_d;
`ifdef BALLOT_SKID_EN
         skid_full_q <= skid_full_d;
         skid_cls_q  <= skid_cls_d;
         skid_id_q   <= skid_id_d;
`endif
      end
   end

   // Vote lines and response are pure functions of registered state.
   assign np_out        = (state_q == DRIVE && cls_q == 2'd0) ? (32'd1 << id_q) : 32'd0;
   assign vip_out       = (state_q == DRIVE && cls_q == 2'd1) ? (8'd1 << id_q[2:0]) : 8'd0;
   assign vvip_out      = (state_q == DRIVE && cls_q == 2'd2);
   assign rsp_valid     = (state_q == RESP);
   assign rsp_ok        = (state_q == RESP) && (code_q == CODE_OK);
   assign rsp_code      = (state_q == RESP) ? RSP_CODE_W'(code_q) : '0;
   assign issued_weight = weight_q;

endmodule

// File: tb/tb_vote_ballot_issuer.sv
// Scoreboard bench for vote_ballot_issuer: driver pushes expected responses,
// a negedge monitor pops and compares them; a bench-side tally follows the vote lines.
module tb_vote_ballot_issuer;

   localparam int HOLD = 2;
   localparam int W    = 34;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_class = 2'd0;
   logic [4:0]  req_id = 5'd0;
   logic [31:0] np_out;
   logic [7:0]  vip_out;
   logic        vvip_out;
   logic        rsp_valid;
   logic        rsp_ok;
   logic [1:0]  rsp_code;
   logic [7:0]  issued_weight;

   logic [W-1:0] exp_q[$];
   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int exp_w   = 0;
   int tally   = 0;
   logic [40:0] prev_lines = '0;

   vote_ballot_issuer #(.HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_class(req_class), .req_id(req_id),
      .np_out(np_out), .vip_out(vip_out), .vvip_out(vvip_out),
      .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_code(rsp_code),
      .issued_weight(issued_weight)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // downstream tally model: weight added on each rising vote line
   always @(negedge clk) begin
      logic [40:0] cur;
      logic [40:0] rise;
      cur  = {np_out, vip_out, vvip_out};
      rise = cur & ~prev_lines;
      tally <= tally + $countones(rise[40:9]) + 4 * $countones(rise[8:1]) + 16 * int'(rise[0]);
      prev_lines <= cur;
   end

   // monitor
   always @(negedge clk) begin
      if (!reset) begin
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", {rsp_ok, rsp_code}, 64'h1ff);
            end else begin
               logic [W-1:0] e;
               e = exp_q.pop_front();
               chk("rsp_cycle", 64'(cyc), 64'(e[W-1:2]));
               chk("rsp_code", 64'(rsp_code), 64'(e[1:0]));
               chk("rsp_ok", 64'(rsp_ok), 64'(e[1:0] == 2'd0));
            end
         end else begin
            if (exp_q.size() != 0 && int'(exp_q[0][W-1:2]) < cyc) begin
               chk("missed_rsp", 64'(cyc), 64'(exp_q[0][W-1:2]));
               void'(exp_q.pop_front());
            end
            if (rsp_ok || rsp_code != 2'd0) chk("rsp_idle_zero", {rsp_ok, rsp_code}, 64'd0);
         end
      end
   end

   // driver tasks
   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("ready_timeout", 64'(req_ready), 64'd1);
   endtask

   task automatic issue(input logic [1:0] c, input logic [4:0] i, input logic [1:0] exp_code,
                        input logic [40:0] exp_lines, input int w_add);
      int t;
      int due;
      @(negedge clk);
      req_valid = 1'b1;
      req_class = c;
      req_id    = i;
      wait_ready();
      @(posedge clk);
      #1;
      t = cyc;
      req_valid = 1'b0;
      req_class = ~c;
      req_id    = ~i;
      due = (exp_code == 2'd0) ? t + 1 + HOLD : t + 1;
      exp_q.push_back({32'(due), exp_code});
      do begin
         @(negedge clk);
         if (exp_code == 2'd0 && cyc >= t + 1 && cyc <= t + HOLD)
            chk("vote_lines", 64'({np_out, vip_out, vvip_out}), 64'(exp_lines));
         else
            chk("vote_lines_off", 64'({np_out, vip_out, vvip_out}), 64'd0);
      end while (cyc < due && cyc < t + 20);
      exp_w += w_add;
      chk("issued_weight", 64'(issued_weight), 64'(exp_w));
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      exp_w = 0;
      chk("clear_weight", 64'(issued_weight), 64'd0);
   endtask

   initial begin
      int t;
      int tally_base;
      repeat (3) @(negedge clk);
      chk("reset_ready", 64'(req_ready), 64'd1);
      chk("reset_lines", 64'({np_out, vip_out, vvip_out, rsp_valid}), 64'd0);
      chk("reset_weight", 64'(issued_weight), 64'd0);
      reset = 1'b0;

      // first ballot and a repeat voter
      issue(2'd0, 5'd5, 2'd0, {32'h0000_0020, 8'h00, 1'b0}, 1);
      issue(2'd0, 5'd5, 2'd1, 41'd0, 0);
      // illegal class/id combinations
      issue(2'd1, 5'd8, 2'd2, 41'd0, 0);
      issue(2'd2, 5'd1, 2'd2, 41'd0, 0);
      issue(2'd3, 5'd0, 2'd2, 41'd0, 0);
      chk("weight_after_rejects", 64'(issued_weight), 64'd1);

      // full electorate after a restart
      do_clear();
      @(negedge clk);
      tally_base = tally;
      for (int i = 0; i < 32; i++) issue(2'd0, 5'(i), 2'd0, {32'd1 << i, 9'd0}, 1);
      for (int i = 0; i < 8; i++)  issue(2'd1, 5'(i), 2'd0, {32'd0, 8'd1 << i, 1'b0}, 4);
      issue(2'd2, 5'd0, 2'd0, {40'd0, 1'b1}, 16);
      repeat (2) @(negedge clk);
      chk("full_weight", 64'(issued_weight), 64'd80);
      chk("tally_match", 64'(tally - tally_base), 64'(issued_weight));

      // clear during DRIVE of vip 3
      do_clear();
      @(negedge clk);
      req_valid = 1'b1;
      req_class = 2'd1;
      req_id    = 5'd3;
      wait_ready();
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("vip3_driving", 64'(vip_out), 64'h08);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("vip3_dropped", 64'(vip_out), 64'd0);
      chk("clear_mid_weight", 64'(issued_weight), 64'd0);
      repeat (4) @(negedge clk);
      exp_w = 0;
      issue(2'd1, 5'd3, 2'd0, {32'd0, 8'h08, 1'b0}, 4);

`ifdef BALLOT_SKID_EN
      // back-to-back duplicate through the skid buffer
      do_clear();
      @(negedge clk);
      req_valid = 1'b1;
      req_class = 2'd0;
      req_id    = 5'd0;
      wait_ready();
      @(posedge clk);
      #1;
      t = cyc;
      exp_q.push_back({32'(t + 1 + HOLD), 2'd0});
      exp_q.push_back({32'(t + 3 + HOLD), 2'd1});
      @(negedge clk);
      chk("skid_ready_busy", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      while (cyc < t + 4 + HOLD) @(negedge clk);
      chk("skid_weight", 64'(issued_weight), 64'd1);
`endif

      repeat (5) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/vote_ballot_issuer.md
Name: vote_ballot_issuer

Overview:
Transmit-side counterpart of the weighted vote tally. It accepts ballot requests (voter class + voter ID) over a valid/ready handshake and rejects ineligible or repeat voters. For each accepted ballot it drives the matching one-hot vote line (np/vip/vvip) toward the tally for a fixed hold time. It keeps a shadow weighted total (np=1, vip=4, vvip=16) that must equal the downstream tally result.

Parameters:
HOLD_CYCLES, 2, cycles a vote line stays asserted per accepted ballot; value 0 is treated as 1
RSP_CODE_W, 2, width of rsp_code (fixed; not to be overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous election restart, highest priority after reset
req_valid  input  1  ballot request valid
req_ready  output  1  issuer can accept a request
req_class  input  2  0=np, 1=vip, 2=vvip, 3=invalid
req_id  input  5  voter index within class
np_out  output  32  normal-voter vote lines, one-hot while driving
vip_out  output  8  VIP vote lines, one-hot while driving
vvip_out  output  1  VVIP vote line
rsp_valid  output  1  one-cycle response strobe
rsp_ok  output  1  1 = ballot issued
rsp_code  output  2  0=issued, 1=duplicate, 2=illegal class/id
issued_weight  output  8  running weighted total of issued ballots

Behaviour:
- Reset (async) and clear (sync): state=IDLE; all outputs 0; used bitmaps (np 32b, vip 8b, vvip 1b) cleared; issued_weight=0. Clear in any state aborts the current ballot and drops vote lines on the next edge. Its bitmap update does not occur.
- FSM states: IDLE, CHECK, DRIVE, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture class and id, then go to CHECK. req_ready=0 in all other states (unless BALLOT_SKID_EN).
- CHECK (1 cycle): evaluated in priority order.
  - Illegal: class==3, or class==vip with id>=8, or class==vvip with id!=0 -> code 2, go to RESP.
  - Duplicate: used bit already set -> code 1, go to RESP.
  - Otherwise: set used bit, add weight to issued_weight, code 0, go to DRIVE.
- DRIVE: exactly one bit of np_out/vip_out/vvip_out asserted, for HOLD_CYCLES cycles, then go to RESP. Vote lines are 0 outside DRIVE.
- RESP: rsp_valid=1 for exactly one cycle, with rsp_ok=(code==0) and rsp_code. Then go to IDLE. rsp_ok/rsp_code are 0 when rsp_valid=0.
- Latency: handshake at edge T.
  - Accepted ballot: vote line high from T+2 through T+1+HOLD_CYCLES; rsp_valid at T+2+HOLD_CYCLES.
  - Rejected ballot: rsp_valid at T+2; no vote line toggles.
- issued_weight: 8-bit, updated on the CHECK->DRIVE edge. Maximum reachable value is 32+32+16=80, so no wrap or saturation path is needed.
- Requests with req_valid high while req_ready=0 are held by the source and are not dropped.
- Request fields are sampled only at the handshake; later changes are ignored.

Optional Feature:
Macro BALLOT_SKID_EN.
- Defined:
  - One-entry request skid buffer; req_ready = !skid_full, in every state.
  - A request accepted while busy is stored.
  - After RESP, a stored request goes directly to CHECK, skipping IDLE, for back-to-back throughput.
  - Duplicate detection sees bitmap updates from the preceding ballot.
  - clear flushes the skid.
- Undefined: no skid; req_ready=1 only in IDLE; behaviour exactly as above.

Test Plan:
1. After reset, req class=0 id=5 -> np_out=0x00000020 for 2 cycles (HOLD_CYCLES=2); rsp_valid 4 cycles after handshake with ok=1, code=0; issued_weight=1.
2. Repeat class=0 id=5 -> no vote line toggles; rsp at T+2 with ok=0, code=1; issued_weight remains 1.
3. Requests class=1 id=8, class=2 id=1, class=3 id=0 -> each gets code=2, no vote lines driven, weight unchanged.
4. Issue all 32 np, 8 vip and 1 vvip -> issued_weight=80; matches an instantiated tally's result=80.
5. Assert clear during DRIVE of vip id 3 -> vip_out=0 next cycle, no rsp, weight=0; re-request vip id 3 -> accepted, weight=4.
6. (BALLOT_SKID_EN) Two back-to-back requests np id 0 and np id 0 -> second accepted while busy; second rsp code=1 immediately after the first RESP, with no IDLE cycle between.
